// File: rtl/ahb_bm_pkg.sv
// Shared bus-matrix constants: HTRANS/HRESP encodings and AHB control field widths.
package ahb_bm_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam int TRANS_W = 2;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 3;
    localparam int PROT_W  = 4;
    localparam int RESP_W  = 2;

    // NONSEQ and SEQ are the only transfer types that carry an address phase.
    function automatic logic trans_is_active(input logic [TRANS_W-1:0] trans);
        return trans[1];
    endfunction

endpackage

// File: rtl/ahb_bm_input_hold_if.sv
// Master-facing slave-port signals of one bus-matrix input stage.
// BM_INPUT_AUSER_EN adds the HAUSERS sideband.
interface ahb_bm_input_hold_if
    import ahb_bm_pkg::*;
#(
    parameter int ADDR_W = 32
`ifdef BM_INPUT_AUSER_EN
  , parameter int AUSER_W = 32
`endif
);
    logic                HSELS;
    logic [ADDR_W-1:0]   HADDRS;
    logic [TRANS_W-1:0]  HTRANSS;
    logic                HWRITES;
    logic [SIZE_W-1:0]   HSIZES;
    logic [BURST_W-1:0]  HBURSTS;
    logic [PROT_W-1:0]   HPROTS;
    logic                HMASTLOCKS;
    logic                HREADYS;
`ifdef BM_INPUT_AUSER_EN
    logic [AUSER_W-1:0]  HAUSERS;
`endif
    logic                HREADYOUTS;
    logic [RESP_W-1:0]   HRESPS;

    modport master (
        output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
`ifdef BM_INPUT_AUSER_EN
        output HAUSERS,
`endif
        input  HREADYOUTS, HRESPS
    );

    modport slave (
        input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
`ifdef BM_INPUT_AUSER_EN
        input  HAUSERS,
`endif
        output HREADYOUTS, HRESPS
    );

endinterface

// File: rtl/ahb_bm_hold_reg.sv
// Load-enabled address-phase field bank with asynchronous clear (trans clears to IDLE).
// BM_INPUT_AUSER_EN adds HAUSER storage.
module ahb_bm_hold_reg
    import ahb_bm_pkg::*;
#(
    parameter int ADDR_W = 32
`ifdef BM_INPUT_AUSER_EN
  , parameter int AUSER_W = 32
`endif
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                load_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [TRANS_W-1:0]  trans_i,
    input  logic                write_i,
    input  logic [SIZE_W-1:0]   size_i,
    input  logic [BURST_W-1:0]  burst_i,
    input  logic [PROT_W-1:0]   prot_i,
    input  logic                mastlock_i,
`ifdef BM_INPUT_AUSER_EN
    input  logic [AUSER_W-1:0]  auser_i,
    output logic [AUSER_W-1:0]  auser_o,
`endif
    output logic [ADDR_W-1:0]   addr_o,
    output logic [TRANS_W-1:0]  trans_o,
    output logic                write_o,
    output logic [SIZE_W-1:0]   size_o,
    output logic [BURST_W-1:0]  burst_o,
    output logic [PROT_W-1:0]   prot_o,
    output logic                mastlock_o
);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_o     <= '0;
            trans_o    <= HTRANS_IDLE;
            write_o    <= 1'b0;
            size_o     <= '0;
            burst_o    <= '0;
            prot_o     <= '0;
            mastlock_o <= 1'b0;
`ifdef BM_INPUT_AUSER_EN
            auser_o    <= '0;
`endif
        end else if (load_i) begin
            addr_o     <= addr_i;
            trans_o    <= trans_i;
            write_o    <= write_i;
            size_o     <= size_i;
            burst_o    <= burst_i;
            prot_o     <= prot_i;
            mastlock_o <= mastlock_i;
`ifdef BM_INPUT_AUSER_EN
            auser_o    <= auser_i;
`endif
        end
    end

endmodule

// File: rtl/ahb_bm_input_hold.sv
// Bus-matrix slave-interface input stage: holds a blocked address phase, stalls the master,
// replays it to the decoder. BM_INPUT_AUSER_EN adds HAUSERS/auser_op.
//
// state bit | meaning
// pend      | holding register owns the address phase; master stalled
// dphase    | a transfer issued by this port is in its data phase
module ahb_bm_input_hold
    import ahb_bm_pkg::*;
#(
    parameter int ADDR_W = 32
`ifdef BM_INPUT_AUSER_EN
  , parameter int AUSER_W = 32
`endif
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    ahb_bm_input_hold_if.slave   s_ahb,
    input  logic                 active_dec,
    input  logic                 readyout_dec,
    input  logic [RESP_W-1:0]    resp_dec,
    output logic                 sel_op,
    output logic [ADDR_W-1:0]    addr_op,
    output logic [TRANS_W-1:0]   trans_op,
    output logic                 write_op,
    output logic [SIZE_W-1:0]    size_op,
    output logic [BURST_W-1:0]   burst_op,
    output logic [PROT_W-1:0]    prot_op,
    output logic                 mastlock_op,
    output logic                 held_tran_op
`ifdef BM_INPUT_AUSER_EN
  , output logic [AUSER_W-1:0]   auser_op
`endif
);

    logic                pend_q, pend_d;
    logic                dphase_q, dphase_d;
    logic                valid_in, capture, issue_live, rel_held, err_cancel;

    logic [ADDR_W-1:0]   h_addr;
    logic [TRANS_W-1:0]  h_trans;
    logic                h_write;
    logic [SIZE_W-1:0]   h_size;
    logic [BURST_W-1:0]  h_burst;
    logic [PROT_W-1:0]   h_prot;
    logic                h_mastlock;
`ifdef BM_INPUT_AUSER_EN
    logic [AUSER_W-1:0]  h_auser;
`endif

    assign valid_in   = s_ahb.HSELS & s_ahb.HREADYS & trans_is_active(s_ahb.HTRANSS);
    assign capture    = ~pend_q & valid_in & ~active_dec;
    assign issue_live = ~pend_q & valid_in & active_dec;
    assign rel_held   = pend_q & active_dec & readyout_dec;
    // First cycle of a two-cycle ERROR: the master may abandon the stalled transfer by going IDLE.
    assign err_cancel = pend_q & dphase_q & (resp_dec == HRESP_ERROR) & ~readyout_dec
                      & (s_ahb.HTRANSS == HTRANS_IDLE);

    ahb_bm_hold_reg #(
        .ADDR_W     (ADDR_W)
`ifdef BM_INPUT_AUSER_EN
      , .AUSER_W    (AUSER_W)
`endif
    ) u_hold_reg (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .load_i     (capture),
        .addr_i     (s_ahb.HADDRS),
        .trans_i    (s_ahb.HTRANSS),
        .write_i    (s_ahb.HWRITES),
        .size_i     (s_ahb.HSIZES),
        .burst_i    (s_ahb.HBURSTS),
        .prot_i     (s_ahb.HPROTS),
        .mastlock_i (s_ahb.HMASTLOCKS),
`ifdef BM_INPUT_AUSER_EN
        .auser_i    (s_ahb.HAUSERS),
        .auser_o    (h_auser),
`endif
        .addr_o     (h_addr),
        .trans_o    (h_trans),
        .write_o    (h_write),
        .size_o     (h_size),
        .burst_o    (h_burst),
        .prot_o     (h_prot),
        .mastlock_o (h_mastlock)
    );

    always_comb begin
        pend_d = pend_q;
        if (capture) begin
            pend_d = 1'b1;
        end else if (rel_held || err_cancel) begin
            pend_d = 1'b0;
        end

        dphase_d = dphase_q;
        if (issue_live || rel_held) begin
            dphase_d = 1'b1;
        end else if (readyout_dec) begin
            dphase_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_q   <= 1'b0;
            dphase_q <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            dphase_q <= dphase_d;
        end
    end

    assign sel_op       = pend_q ? 1'b1       : (s_ahb.HSELS & s_ahb.HREADYS);
    assign addr_op      = pend_q ? h_addr     : s_ahb.HADDRS;
    assign trans_op     = pend_q ? h_trans    : (s_ahb.HREADYS ? s_ahb.HTRANSS : HTRANS_IDLE);
    assign write_op     = pend_q ? h_write    : s_ahb.HWRITES;
    assign size_op      = pend_q ? h_size     : s_ahb.HSIZES;
    assign burst_op     = pend_q ? h_burst    : s_ahb.HBURSTS;
    assign prot_op      = pend_q ? h_prot     : s_ahb.HPROTS;
    assign mastlock_op  = pend_q ? h_mastlock : s_ahb.HMASTLOCKS;
    assign held_tran_op = pend_q;
`ifdef BM_INPUT_AUSER_EN
    assign auser_op     = pend_q ? h_auser    : s_ahb.HAUSERS;
`endif

    assign s_ahb.HREADYOUTS = dphase_q ? readyout_dec : ~pend_q;
    assign s_ahb.HRESPS     = dphase_q ? resp_dec     : HRESP_OKAY;

    // The master is stalled while pend is set, so a fresh address phase cannot coincide with replay.
    a_no_release_overlap: assert property (@(posedge HCLK) disable iff (!HRESETn)
        !(rel_held && valid_in));

endmodule

// File: tb/tb_ahb_bm_input_hold.sv
// Directed bench for ahb_bm_input_hold; define BM_INPUT_AUSER_EN to also exercise HAUSER holding.
module tb_ahb_bm_input_hold;
    import ahb_bm_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        active_dec, readyout_dec;
    logic [1:0]  resp_dec;
    logic        sel_op, write_op, mastlock_op, held_tran_op;
    logic [31:0] addr_op;
    logic [1:0]  trans_op;
    logic [2:0]  size_op, burst_op;
    logic [3:0]  prot_op;
`ifdef BM_INPUT_AUSER_EN
    logic [31:0] auser_op;
`endif
    int total = 0;
    int bad   = 0;

    ahb_bm_input_hold_if bus ();

    ahb_bm_input_hold dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .s_ahb        (bus.slave),
        .active_dec   (active_dec),
        .readyout_dec (readyout_dec),
        .resp_dec     (resp_dec),
        .sel_op       (sel_op),
        .addr_op      (addr_op),
        .trans_op     (trans_op),
        .write_op     (write_op),
        .size_op      (size_op),
        .burst_op     (burst_op),
        .prot_op      (prot_op),
        .mastlock_op  (mastlock_op),
        .held_tran_op (held_tran_op)
`ifdef BM_INPUT_AUSER_EN
      , .auser_op     (auser_op)
`endif
    );

    always #5 HCLK = ~HCLK;

    task automatic next();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.HSELS      = 1'b0;
        bus.HADDRS     = '0;
        bus.HTRANSS    = HTRANS_IDLE;
        bus.HWRITES    = 1'b0;
        bus.HSIZES     = '0;
        bus.HBURSTS    = '0;
        bus.HPROTS     = '0;
        bus.HMASTLOCKS = 1'b0;
        bus.HREADYS    = 1'b1;
`ifdef BM_INPUT_AUSER_EN
        bus.HAUSERS    = '0;
`endif
        active_dec     = 1'b1;
        readyout_dec   = 1'b1;
        resp_dec       = HRESP_OKAY;
    endtask

    task automatic drive_nonseq(input logic [31:0] addr, input logic act);
        bus.HSELS   = 1'b1;
        bus.HTRANSS = HTRANS_NONSEQ;
        bus.HADDRS  = addr;
        bus.HREADYS = 1'b1;
        active_dec  = act;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        idle_inputs();
        #3;
        total++; if (bus.HREADYOUTS !== 1'b1) begin bad++; $display("FAIL reset_hreadyout: got %0b want 1", bus.HREADYOUTS); end
        total++; if (bus.HRESPS !== HRESP_OKAY) begin bad++; $display("FAIL reset_hresp: got %0h want 0", bus.HRESPS); end
        total++; if (sel_op !== 1'b0) begin bad++; $display("FAIL reset_sel: got %0b want 0", sel_op); end
        total++; if (held_tran_op !== 1'b0) begin bad++; $display("FAIL reset_held: got %0b want 0", held_tran_op); end
        total++; if (trans_op !== HTRANS_IDLE) begin bad++; $display("FAIL reset_trans: got %0h want 0", trans_op); end
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
    endtask

    task automatic test_unblocked();
        next();
        drive_nonseq(32'h2000_0000, 1'b1);
        #1;
        total++; if (trans_op !== HTRANS_NONSEQ) begin bad++; $display("FAIL unblk_trans: got %0h want 2", trans_op); end
        total++; if (addr_op !== 32'h2000_0000) begin bad++; $display("FAIL unblk_addr: got %0h want 20000000", addr_op); end
        total++; if (held_tran_op !== 1'b0) begin bad++; $display("FAIL unblk_held: got %0b want 0", held_tran_op); end
        total++; if (sel_op !== 1'b1) begin bad++; $display("FAIL unblk_sel: got %0b want 1", sel_op); end
        next();
        idle_inputs();
        readyout_dec = 1'b0;
        #1;
        total++; if (bus.HREADYOUTS !== 1'b0) begin bad++; $display("FAIL unblk_dphase_lo: got %0b want 0", bus.HREADYOUTS); end
        readyout_dec = 1'b1;
        #1;
        total++; if (bus.HREADYOUTS !== 1'b1) begin bad++; $display("FAIL unblk_dphase_hi: got %0b want 1", bus.HREADYOUTS); end
        next();
        readyout_dec = 1'b0;
        #1;
        total++; if (bus.HREADYOUTS !== 1'b1) begin bad++; $display("FAIL unblk_dphase_end: got %0b want 1", bus.HREADYOUTS); end
        readyout_dec = 1'b1;
    endtask

    task automatic test_wait_states();
        logic [3:0] rdy_seq;
        int lows;
        rdy_seq = 4'b1100;
        lows = 0;
        next();
        drive_nonseq(32'h2000_0040, 1'b1);
        next();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            readyout_dec = rdy_seq[i];
            bus.HREADYS  = rdy_seq[i];
            #1;
            if (bus.HREADYOUTS === 1'b0) lows++;
            next();
        end
        total++; if (lows !== 2) begin bad++; $display("FAIL wait_state_count: got %0d want 2", lows); end
        idle_inputs();
    endtask

    task automatic test_blocked();
        next();
        drive_nonseq(32'h4000_0100, 1'b0);
        bus.HWRITES = 1'b1;
        bus.HSIZES  = 3'd2;
        bus.HBURSTS = 3'd1;
        bus.HPROTS  = 4'd3;
        #1;
        total++; if (held_tran_op !== 1'b0) begin bad++; $display("FAIL blk_capture_cycle_held: got %0b want 0", held_tran_op); end
        next();
        bus.HTRANSS = HTRANS_IDLE;
        bus.HADDRS  = 32'hDEAD_0000;
        bus.HWRITES = 1'b0;
        bus.HSIZES  = 3'd0;
        bus.HREADYS = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (held_tran_op !== 1'b1) begin bad++; $display("FAIL blk_held[%0d]: got %0b want 1", i, held_tran_op); end
            total++; if (addr_op !== 32'h4000_0100) begin bad++; $display("FAIL blk_addr[%0d]: got %0h want 40000100", i, addr_op); end
            total++; if (trans_op !== HTRANS_NONSEQ) begin bad++; $display("FAIL blk_trans[%0d]: got %0h want 2", i, trans_op); end
            total++; if (write_op !== 1'b1 || size_op !== 3'd2) begin bad++; $display("FAIL blk_ctrl[%0d]: got w=%0b s=%0d want w=1 s=2", i, write_op, size_op); end
            total++; if (sel_op !== 1'b1) begin bad++; $display("FAIL blk_sel[%0d]: got %0b want 1", i, sel_op); end
            total++; if (bus.HREADYOUTS !== 1'b0) begin bad++; $display("FAIL blk_stall[%0d]: got %0b want 0", i, bus.HREADYOUTS); end
            next();
        end
        active_dec = 1'b1;
        #1;
        total++; if (bus.HREADYOUTS !== 1'b0) begin bad++; $display("FAIL blk_release_cycle_ready: got %0b want 0", bus.HREADYOUTS); end
        next();
        bus.HSELS   = 1'b0;
        bus.HREADYS = 1'b1;
        #1;
        total++; if (held_tran_op !== 1'b0) begin bad++; $display("FAIL blk_after_release_held: got %0b want 0", held_tran_op); end
        total++; if (trans_op !== HTRANS_IDLE) begin bad++; $display("FAIL blk_after_release_trans: got %0h want 0", trans_op); end
        total++; if (bus.HREADYOUTS !== 1'b1) begin bad++; $display("FAIL blk_data_ready: got %0b want 1", bus.HREADYOUTS); end
        readyout_dec = 1'b0;
        #1;
        total++; if (bus.HREADYOUTS !== 1'b0) begin bad++; $display("FAIL blk_data_follow: got %0b want 0", bus.HREADYOUTS); end
        readyout_dec = 1'b1;
        next();
        idle_inputs();
    endtask

    task automatic test_err_cancel();
        next();
        drive_nonseq(32'h1000_0000, 1'b1);
        next();
        drive_nonseq(32'h3000_0200, 1'b0);
        readyout_dec = 1'b0;
        next();
        bus.HTRANSS  = HTRANS_IDLE;
        bus.HSELS    = 1'b0;
        bus.HREADYS  = 1'b0;
        resp_dec     = HRESP_ERROR;
        #1;
        total++; if (held_tran_op !== 1'b1) begin bad++; $display("FAIL err_pre_held: got %0b want 1", held_tran_op); end
        total++; if (bus.HRESPS !== HRESP_ERROR) begin bad++; $display("FAIL err_resp1: got %0h want 1", bus.HRESPS); end
        total++; if (bus.HREADYOUTS !== 1'b0) begin bad++; $display("FAIL err_ready1: got %0b want 0", bus.HREADYOUTS); end
        next();
        readyout_dec = 1'b1;
        bus.HREADYS  = 1'b1;
        #1;
        total++; if (held_tran_op !== 1'b0) begin bad++; $display("FAIL err_cancel_held: got %0b want 0", held_tran_op); end
        total++; if (trans_op !== HTRANS_IDLE) begin bad++; $display("FAIL err_cancel_trans: got %0h want 0", trans_op); end
        total++; if (bus.HRESPS !== HRESP_ERROR || bus.HREADYOUTS !== 1'b1) begin bad++; $display("FAIL err_resp2: got resp=%0h rdy=%0b want resp=1 rdy=1", bus.HRESPS, bus.HREADYOUTS); end
        next();
        idle_inputs();
    endtask

    task automatic test_reset_mid_hold();
        next();
        drive_nonseq(32'h5000_0000, 1'b0);
        next();
        bus.HTRANSS = HTRANS_IDLE;
        bus.HREADYS = 1'b0;
        #1;
        total++; if (held_tran_op !== 1'b1) begin bad++; $display("FAIL rst_hold_pre: got %0b want 1", held_tran_op); end
        #1 HRESETn = 1'b0;
        #1;
        total++; if (bus.HREADYOUTS !== 1'b1) begin bad++; $display("FAIL rst_hold_ready: got %0b want 1", bus.HREADYOUTS); end
        total++; if (sel_op !== 1'b0) begin bad++; $display("FAIL rst_hold_sel: got %0b want 0", sel_op); end
        total++; if (held_tran_op !== 1'b0) begin bad++; $display("FAIL rst_hold_held: got %0b want 0", held_tran_op); end
        idle_inputs();
        next();
        HRESETn = 1'b1;
        next();
        total++; if (held_tran_op !== 1'b0 || bus.HREADYOUTS !== 1'b1) begin bad++; $display("FAIL rst_hold_after: got held=%0b rdy=%0b want 0 1", held_tran_op, bus.HREADYOUTS); end
    endtask

`ifdef BM_INPUT_AUSER_EN
    task automatic test_auser();
        next();
        drive_nonseq(32'h6000_0000, 1'b0);
        bus.HAUSERS = 32'hA5A5_0001;
        next();
        bus.HAUSERS = 32'h0;
        bus.HTRANSS = HTRANS_IDLE;
        bus.HREADYS = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++; if (auser_op !== 32'hA5A5_0001) begin bad++; $display("FAIL auser_held[%0d]: got %0h want a5a50001", i, auser_op); end
            next();
        end
        active_dec = 1'b1;
        next();
        bus.HSELS   = 1'b0;
        bus.HREADYS = 1'b1;
        #1;
        total++; if (auser_op !== 32'h0) begin bad++; $display("FAIL auser_released: got %0h want 0", auser_op); end
        next();
        idle_inputs();
    endtask
`endif

    initial begin
        test_reset();
        test_unblocked();
        test_wait_states();
        test_blocked();
        test_err_cancel();
        test_reset_mid_hold();
`ifdef BM_INPUT_AUSER_EN
        test_auser();
`endif
        repeat (2) next();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
